// File: rtl/truncador_sat_pipe.sv
// truncador_sat_pipe: two-stage Q(2N-2F).(2F) -> Q(N-F).F truncator with saturation and overflow stats
// Define TRUNC_ROUND_EN to round half toward +inf instead of flooring.
module truncador_sat_pipe #(
    parameter int N     = 16,
    parameter int F     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dato_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     resultado,
    output logic             sat_pos,
    output logic             sat_neg,
    input  logic             clr_stats,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] sat_count
);
    localparam int SW = 2*N+1-F;

    logic          stall, v1, pos, neg, xfer_sat, unused_lsb;
    logic [2*N:0]  s;
    logic [SW-1:0] s1;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

`ifdef TRUNC_ROUND_EN
    localparam logic [2*N:0] RND = (2*N+1)'(1) << (F-1);
    assign s = {dato_in[2*N-1], dato_in} + RND;
`else
    assign s = {dato_in[2*N-1], dato_in};
`endif
    assign unused_lsb = ^s[F-1:0];

    // Bits above the N-bit result must all equal the sign bit, otherwise clamp.
    assign pos      = !s1[SW-1] && (|s1[SW-2:N-1]);
    assign neg      = s1[SW-1] && !(&s1[SW-2:N-1]);
    assign xfer_sat = out_valid && out_ready && (sat_pos || sat_neg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            resultado <= '0;
            sat_pos   <= 1'b0;
            sat_neg   <= 1'b0;
        end else if (!stall) begin
            v1        <= in_valid;
            s1        <= s[2*N:F];
            out_valid <= v1;
            resultado <= pos ? {1'b0, {(N-1){1'b1}}} : neg ? {1'b1, {(N-1){1'b0}}} : s1[N-1:0];
            sat_pos   <= v1 && pos;
            sat_neg   <= v1 && neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            sat_count  <= '0;
        end else begin
            ovf_sticky <= xfer_sat ? 1'b1 : clr_stats ? 1'b0 : ovf_sticky;
            sat_count  <= xfer_sat ? (clr_stats ? CNT_W'(1) : (&sat_count) ? sat_count : sat_count + CNT_W'(1))
                        : clr_stats ? '0 : sat_count;
        end
    end
endmodule

// File: tb/tb_truncador_sat_pipe.sv
// tb_truncador_sat_pipe: directed checks of truncation, saturation, flow control and statistics.
// A second instance with a 2-bit counter exercises the counter hold at all-ones.
module tb_truncador_sat_pipe;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, clr_stats = 0;
    logic [31:0] dato_in = '0;
    logic        in_ready, out_valid, sat_pos, sat_neg, ovf_sticky;
    logic [15:0] resultado, sat_count;
    logic        s_in_ready, s_out_valid, s_sat_pos, s_sat_neg, s_ovf_sticky;
    logic [15:0] s_resultado;
    logic [1:0]  s_sat_count;
    int          checks = 0, errors = 0;
    logic [15:0] rec [0:15];
    int          nrec, sent, nstall;

    always #5 clk = ~clk;

    truncador_sat_pipe #(.N(16), .F(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .dato_in(dato_in),
        .out_valid(out_valid), .out_ready(out_ready), .resultado(resultado), .sat_pos(sat_pos),
        .sat_neg(sat_neg), .clr_stats(clr_stats), .ovf_sticky(ovf_sticky), .sat_count(sat_count)
    );

    truncador_sat_pipe #(.N(16), .F(8), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .dato_in(dato_in),
        .out_valid(s_out_valid), .out_ready(out_ready), .resultado(s_resultado), .sat_pos(s_sat_pos),
        .sat_neg(s_sat_neg), .clr_stats(clr_stats), .ovf_sticky(s_ovf_sticky), .sat_count(s_sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [31:0] x);
        @(negedge clk);
        in_valid = 1;
        dato_in  = x;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic out3(input string tag, input logic [15:0] r, input logic p, input logic n);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_res"}, {16'b0, resultado}, {16'b0, r});
        chk({tag, "_flags"}, {30'b0, sat_pos, sat_neg}, {30'b0, p, n});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_res", {16'b0, resultado}, 32'd0);
        chk("rst_flags", {30'b0, sat_pos, sat_neg}, 32'd0);
        chk("rst_stats", {15'b0, ovf_sticky, sat_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1;

        go(32'h0001_8000);
        out3("p1_5", 16'h0180, 0, 0);
        @(negedge clk);
        chk("p1_5_stats", {15'b0, ovf_sticky, sat_count}, 32'd0);
        chk("bubble_valid", {31'b0, out_valid}, 32'd0);

        go(32'h0100_0000);
        out3("pos256", 16'h7FFF, 1, 0);
        @(negedge clk);
        chk("pos256_stats", {15'b0, ovf_sticky, sat_count}, {15'b0, 1'b1, 16'd1});

        go(32'hFF00_0000);
        out3("neg256", 16'h8000, 0, 1);
        @(negedge clk);
        chk("neg256_cnt", {16'b0, sat_count}, 32'd2);

        go(32'hFF80_0000);
        out3("exact_min", 16'h8000, 0, 0);
        @(negedge clk);
        chk("exact_min_cnt", {16'b0, sat_count}, 32'd2);

`ifdef TRUNC_ROUND_EN
        go(32'h0000_0080);
        out3("half_pos", 16'h0001, 0, 0);
        go(32'hFFFF_FF80);
        out3("half_neg", 16'h0000, 0, 0);
        go(32'h007F_FFFF);
        out3("round_max", 16'h7FFF, 1, 0);
        @(negedge clk);
        chk("round_cnt", {16'b0, sat_count}, 32'd3);
`else
        go(32'h0000_0080);
        out3("half_pos", 16'h0000, 0, 0);
        go(32'hFFFF_FF80);
        out3("half_neg", 16'hFFFF, 0, 0);
        go(32'h007F_FFFF);
        out3("round_max", 16'h7FFF, 0, 0);
        @(negedge clk);
        chk("round_cnt", {16'b0, sat_count}, 32'd2);
`endif

        go(32'h0100_0000);
        go(32'h0100_0000);
        @(negedge clk);
`ifdef TRUNC_ROUND_EN
        chk("cnt_more", {16'b0, sat_count}, 32'd5);
`else
        chk("cnt_more", {16'b0, sat_count}, 32'd4);
`endif
        chk("small_hold", {30'b0, s_sat_count}, 32'd3);
        go(32'h0100_0000);
        @(negedge clk);
        chk("small_hold2", {30'b0, s_sat_count}, 32'd3);

        go(32'hFF00_0000);
        clr_stats = 1;
        @(negedge clk);
        clr_stats = 0;
        chk("clr_sat_cnt", {16'b0, sat_count}, 32'd1);
        chk("clr_sat_sticky", {31'b0, ovf_sticky}, 32'd1);
        chk("clr_sat_small", {30'b0, s_sat_count}, 32'd1);
        clr_stats = 1;
        @(negedge clk);
        clr_stats = 0;
        chk("clr_only", {15'b0, ovf_sticky, sat_count}, 32'd0);

        nrec = 0; sent = 0; nstall = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c < 8);
            in_valid  = sent < 8;
            dato_in   = (sent + 1) << 16;
            #1;
            if (out_valid && !out_ready) begin
                nstall++;
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready && nrec < 16) rec[nrec++] = resultado;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 0; out_ready = 1;
        chk("stall_cycles", nstall, 32'd3);
        chk("stream_count", nrec, 32'd8);
        for (int i = 0; i < 8; i++) chk("stream_data", {16'b0, rec[i]}, (i + 1) << 8);

        @(negedge clk);
        in_valid = 1; dato_in = 32'h0100_0000;
        @(negedge clk);
        dato_in = 32'hFF00_0000;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_cnt", {16'b0, sat_count}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_stats", {15'b0, ovf_sticky, sat_count}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_cnt", {16'b0, sat_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
